// File: rtl/alu_mdu_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer driving the shared ALU.
// Owns HI/LO; one ALU add or subtract per cycle for 32 cycles.
module alu_mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic [31:0] opnd;
  logic [31:0] rs_lat;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div0;

  logic        sgn;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic        carry;
  logic        bw;
  logic [63:0] prod;
  logic [63:0] prod_neg;

  always_comb begin
    sgn    = op[0];
    rs_mag = (sgn && rs_val[31]) ? -rs_val : rs_val;
    rt_mag = (sgn && rt_val[31]) ? -rt_val : rt_val;
  end

  always_comb begin
    alu_ctl = CTL_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (state == CALC) begin
      alu_b = opnd;
      if (is_div) begin
        alu_ctl = CTL_SUB;
        alu_a   = {acc_hi[30:0], acc_lo[31]};
      end else begin
        alu_a   = acc_hi;
      end
    end
  end

  // Carry/borrow recovered from operand and result sign bits only.
  always_comb begin
    carry = (alu_a[31] & alu_b[31])
          | ((alu_a[31] | alu_b[31]) & ~alu_out[31]);
    bw    = (~alu_a[31] & alu_b[31])
          | (~(alu_a[31] ^ alu_b[31]) & alu_out[31]);
    prod     = {acc_hi, acc_lo};
    prod_neg = -prod;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      rs_lat <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div <= op[1];
            neg_q  <= sgn & (rs_val[31] ^ rt_val[31]);
            neg_r  <= sgn & rs_val[31];
            div0   <= op[1] & (rt_val == '0);
            rs_lat <= rs_val;
            acc_hi <= '0;
            acc_lo <= rs_mag;
            opnd   <= rt_mag;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (is_div) begin
            if (acc_hi[31] | ~bw) begin
              acc_hi <= alu_out;
              acc_lo <= {acc_lo[30:0], 1'b1};
            end else begin
              acc_hi <= alu_a;
              acc_lo <= {acc_lo[30:0], 1'b0};
            end
          end else if (acc_lo[0]) begin
            {acc_hi, acc_lo} <= {carry, alu_out, acc_lo[31:1]};
          end else begin
            {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (div0) begin
            hi <= rs_lat;
            lo <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            hi <= neg_r ? -acc_hi : acc_hi;
            lo <= neg_q ? -acc_lo : acc_lo;
          end else begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
